pixel_streamer: RTL
===================

Name: pixel_streamer

Overview:
- Source-side transmitter for the line-buffered 3x3 window loader.
- Reads an 8-bit grayscale image from a synchronous-read frame RAM in raster order and emits it as a pixel_out/pixel_out_valid stream, one pixel per cycle.
- Paces whole lines with a line-credit counter, so it never sends more lines than the downstream 4-line buffer can hold.
- Downstream returns one credit per line it finishes reading.

Parameters:
IMAGE_WIDTH, 512, pixels per line
IMAGE_HEIGHT, 512, lines per frame
ADDR_W, 18, frame RAM address width (>= clog2(IMAGE_WIDTH*IMAGE_HEIGHT))
LINE_CREDITS, 4, downstream line-buffer capacity in lines; initial credit count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  pulse; begins a frame transfer when idle
line_consumed  in  1  pulse; downstream has finished reading one line, returns one credit
mem_rd_en  out  1  frame RAM read strobe
mem_addr  out  ADDR_W  frame RAM address, valid when mem_rd_en=1
mem_rd_data  in  8  RAM read data, valid exactly 1 cycle after mem_rd_en
pixel_out  out  8  streamed pixel
pixel_out_valid  out  1  pixel_out qualifier
busy  out  1  high from start acceptance until done
done  out  1  1-cycle pulse after the last pixel of the frame
credit_err  out  1  sticky; line_consumed received while credits already at LINE_CREDITS

Behaviour:
- Reset: all outputs are 0, state=IDLE, credits=0, col=0, row=0, and all internal read pipeline valids are cleared.
  - Reset mid-frame abandons the frame; no stale pixel_out_valid appears after rst deasserts.
- States: IDLE, WAIT_CREDIT, SEND, FLUSH.
- IDLE:
  - start=1 moves to SEND, with credits=LINE_CREDITS, row=0, col=0, busy=1.
  - start is ignored in every other state.
- Credit rule: one credit is consumed at the first pixel read (col=0) of each line.
  - A line is never started while credits=0.
- SEND: mem_rd_en=1 and mem_addr=row*IMAGE_WIDTH+col (running linear counter; no multiplier). col increments every cycle.
  - At col=IMAGE_WIDTH-1 with row<IMAGE_HEIGHT-1: col wraps to 0 and row increments.
    - If credits after this line's debit, plus any line_consumed this cycle, is >0, stay in SEND; the next line follows with no gap cycle.
    - Otherwise go to WAIT_CREDIT.
  - At col=IMAGE_WIDTH-1 with row=IMAGE_HEIGHT-1: go to FLUSH.
- WAIT_CREDIT: mem_rd_en=0. line_consumed=1 moves to SEND next cycle.
- FLUSH: waits until the last pixel_out_valid has been emitted (2 cycles). done=1 in the cycle after the last pixel_out_valid, then return to IDLE with busy=0.
- Latency: mem_rd_en in cycle t gives RAM data in cycle t+1. The block registers it, so pixel_out/pixel_out_valid appear in cycle t+2.
  - The valid pattern is an exact 2-cycle-delayed copy of mem_rd_en.
  - The first pixel_out_valid occurs 3 cycles after the cycle in which start=1 is sampled.
- Credit counter: width clog2(LINE_CREDITS+1).
  - Simultaneous debit (line start) and line_consumed: net 0 change.
  - line_consumed at credits=LINE_CREDITS with no same-cycle debit: count is unchanged and credit_err is set.
  - credit_err clears only on rst.
- line_consumed is honoured in every state, including IDLE and FLUSH, for return-credit accounting. Credits are reloaded to LINE_CREDITS on each start.
- Within a line, pixel_out_valid has no gaps. Gaps occur only between lines while in WAIT_CREDIT.

Test Plan (IMAGE_WIDTH=8, IMAGE_HEIGHT=6, LINE_CREDITS=4, RAM[a]=a):
1. start, line_consumed never pulsed:
   - 32 contiguous valid pixels, values 0..31, first valid 3 cycles after start.
   - Then stall in WAIT_CREDIT: mem_rd_en=0, busy=1, done=0.
2. Continue 1: pulse line_consumed once:
   - Exactly 8 more pixels (32..39), then stall again.
   - Pulse again: pixels 40..47, done pulses 1 cycle after pixel 47, busy drops, total valid count=48.
3. start with line_consumed pulsed every 8 cycles from the first valid pixel:
   - 48 pixels with no gaps.
   - Credits never reach 0 after line 4; done follows pixel 47.
4. line_consumed at the same edge the 5th line would start, with credits=0 before it:
   - Line 5 starts at most 1 cycle after the pulse (no credit lost).
   - At a debit-plus-return edge in SEND, the credit count is unchanged.
5. Pulse line_consumed while idle after reset (credits=LINE_CREDITS after a previous start):
   - credit_err=1 and stays 1 until rst.
   - start during busy is ignored; the pixel sequence is unaffected.
6. Assert rst for 1 cycle while streaming pixel 20:
   - From the next cycle pixel_out_valid=0, busy=0, done never pulses.
   - A new start restarts at pixel 0 with 4 fresh credits.

Source files
------------

// File: rtl/pixel_streamer.sv
// pixel_streamer
//
// Source-side transmitter for the line-buffered 3x3 window loader. It reads an
// 8-bit grayscale frame from a synchronous-read RAM in raster order and emits
// it as a one-pixel-per-cycle stream. Whole lines are paced by a line-credit
// counter, so the downstream line buffer (LINE_CREDITS lines deep) never
// overflows. Downstream returns one credit per line it has finished reading.
//
// Ports:
//   clk             in   clock, all logic on the rising edge
//   rst             in   synchronous reset, active-high
//   start           in   pulse, begins a frame transfer when idle
//   line_consumed   in   pulse, downstream finished one line (returns a credit)
//   mem_rd_en       out  frame RAM read strobe
//   mem_addr        out  frame RAM address, valid while mem_rd_en=1
//   mem_rd_data     in   RAM data, valid exactly one cycle after mem_rd_en
//   pixel_out       out  streamed pixel
//   pixel_out_valid out  pixel_out qualifier (mem_rd_en delayed by two cycles)
//   busy            out  high from start acceptance until the frame completes
//   done            out  one-cycle pulse after the last pixel of the frame
//   credit_err      out  sticky, a credit came back while the counter was full

module pixel_streamer #(
  parameter int unsigned IMAGE_WIDTH  = 512,
  parameter int unsigned IMAGE_HEIGHT = 512,
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned LINE_CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              line_consumed,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_out_valid,
  output logic              busy,
  output logic              done,
  output logic              credit_err
);

  localparam int unsigned ColW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned RowW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned CredW = $clog2(LINE_CREDITS + 1);

  localparam logic [ColW-1:0]  ColLast  = ColW'(IMAGE_WIDTH - 1);
  localparam logic [RowW-1:0]  RowLast  = RowW'(IMAGE_HEIGHT - 1);
  localparam logic [CredW-1:0] CredFull = CredW'(LINE_CREDITS);

  localparam logic [1:0] StIdle       = 2'd0;
  localparam logic [1:0] StWaitCredit = 2'd1;
  localparam logic [1:0] StSend       = 2'd2;
  localparam logic [1:0] StFlush      = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CredW-1:0]  credits_q, credits_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  // Read pipeline: rd_vld_q marks mem_rd_data as valid this cycle,
  // pix_vld_q/pix_q are the registered output stage.
  logic              rd_vld_q;
  logic              pix_vld_q;
  logic [7:0]        pix_q;

  logic              debit;

  // A line costs its credit on its first read (col 0).
  assign debit = (state_q == StSend) && (col_q == '0);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    credits_d = credits_q;
    err_d     = err_q;
    done_d    = 1'b0;

    // Credit accounting runs in every state; a same-cycle debit and return
    // cancel out, and a return into a full counter is flagged, not counted.
    if (debit && !line_consumed) begin
      credits_d = credits_q - CredW'(1);
    end else if (!debit && line_consumed) begin
      if (credits_q == CredFull) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CredW'(1);
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSend;
          credits_d = CredFull;
          col_d     = '0;
          row_d     = '0;
          addr_d    = '0;
        end
      end

      StWaitCredit: begin
        if (line_consumed) begin
          state_d = StSend;
        end
      end

      StSend: begin
        // Linear address counter stands in for row*IMAGE_WIDTH+col.
        addr_d = addr_q + ADDR_W'(1);
        if (col_q == ColLast) begin
          col_d = '0;
          if (row_q == RowLast) begin
            state_d = StFlush;
          end else begin
            row_d = row_q + RowW'(1);
            // credits_d already includes this line's debit and any return
            // arriving this cycle; only stall when nothing is left.
            if (credits_d == '0) begin
              state_d = StWaitCredit;
            end
          end
        end else begin
          col_d = col_q + ColW'(1);
        end
      end

      StFlush: begin
        // Last pixel is on the output now and nothing is left in flight.
        if (pix_vld_q && !rd_vld_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      credits_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      pix_vld_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      done_q    <= done_d;
      rd_vld_q  <= mem_rd_en;
      pix_vld_q <= rd_vld_q;
      if (rd_vld_q) begin
        pix_q <= mem_rd_data;
      end
    end
  end

  assign mem_rd_en       = (state_q == StSend);
  assign mem_addr        = addr_q;
  assign pixel_out       = pix_q;
  assign pixel_out_valid = pix_vld_q;
  assign busy            = (state_q != StIdle);
  assign done            = done_q;
  assign credit_err      = err_q;

endmodule
